// File: rtl/serializer_pkg.sv
// Shared types and sizing helpers for the byte serializer and its hold buffer.
package serializer_pkg;

    localparam int unsigned SER_WIDTH_DEFAULT = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Bit counter width; a 1-bit frame still needs a 1-bit counter.
    function automatic int unsigned ser_cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serializer_hold_buffer.sv
// One-entry holding register that lets the next byte wait while the current frame shifts out.
module serializer_hold_buffer
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH = SER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             drain_i,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Write and drain are mutually exclusive: a write needs the entry empty, a drain needs it full.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (wr_i) begin
            full_d = 1'b1;
            data_d = wr_data_i;
        end else if (drain_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial feeder: emits accepted bytes MSB first into a downstream serial-in shift register.
module byte_serializer
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH      = SER_WIDTH_DEFAULT,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             shift_out,
    output logic             bit_valid,
    output logic             last_bit,
    output logic             frame_done,
    output logic             busy
);

    localparam int unsigned    CW       = ser_cnt_width(WIDTH);
    localparam logic [0:0]     ST_IDLE  = IDLE;
    localparam logic [0:0]     ST_SHIFT = SHIFT;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             shift_out_q, shift_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             last_bit_q, last_bit_d;
    logic             frame_done_q;
    logic             busy_q, busy_d;
    logic             in_ready_q, in_ready_d;

    logic             accept;
    logic             hold_wr;
    logic             hold_drain;
    logic             hold_full;
    logic             hold_full_nxt;
    logic [WIDTH-1:0] hold_data;

    serializer_hold_buffer #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .wr_i      (hold_wr),
        .wr_data_i (in_data),
        .drain_i   (hold_drain),
        .full_o    (hold_full),
        .data_o    (hold_data)
    );

    assign accept = in_valid && !hold_full;

    // Next state: on the last-bit edge a held byte wins over a same-edge bypass.
    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        cnt_d      = cnt_q;
        hold_wr    = 1'b0;
        hold_drain = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_SHIFT;
                    active_d = in_data;
                    cnt_d    = CNT_LOAD;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == '0) begin
                    if (hold_full) begin
                        active_d   = hold_data;
                        cnt_d      = CNT_LOAD;
                        hold_drain = 1'b1;
                    end else if (accept) begin
                        active_d = in_data;
                        cnt_d    = CNT_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    active_d = active_q << 1;
                    cnt_d    = cnt_q - CW'(1);
                    hold_wr  = accept;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are precomputed from next state so they leave the block straight from flops.
    always_comb begin
        hold_full_nxt = hold_wr || (hold_full && !hold_drain);
        shift_out_d   = (state_d == ST_SHIFT) ? active_d[WIDTH-1] : IDLE_LEVEL;
        bit_valid_d   = (state_d == ST_SHIFT);
        last_bit_d    = (state_d == ST_SHIFT) && (cnt_d == '0);
        busy_d        = (state_d == ST_SHIFT) || hold_full_nxt;
        in_ready_d    = !hold_full_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            active_q     <= '0;
            cnt_q        <= '0;
            shift_out_q  <= IDLE_LEVEL;
            bit_valid_q  <= 1'b0;
            last_bit_q   <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            cnt_q        <= cnt_d;
            shift_out_q  <= shift_out_d;
            bit_valid_q  <= bit_valid_d;
            last_bit_q   <= last_bit_d;
            frame_done_q <= last_bit_q;
            busy_q       <= busy_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign shift_out  = shift_out_q;
    assign bit_valid  = bit_valid_q;
    assign last_bit   = last_bit_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: two instances (idle level 0 and 1) share stimulus and are checked
// against a bit-queue model plus a model of the downstream serial-in shift register.
module tb_byte_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;

    logic rdy0, so0, bv0, lb0, fd0, busy0;
    logic rdy1, so1, bv1, lb1, fd1, busy1;
    logic [7:0] out0, out1;

    int checks = 0;
    int errors = 0;

    // Model: every accepted byte appends its 8 bits (MSB first) to a bit queue; one bit leaves per cycle.
    logic       bq[$];
    logic [7:0] frames[$];
    logic       fd_exp;
    logic       acc_last;

    byte_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy0), .shift_out(so0), .bit_valid(bv0), .last_bit(lb0),
        .frame_done(fd0), .busy(busy0)
    );

    byte_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy1), .shift_out(so1), .bit_valid(bv1), .last_bit(lb1),
        .frame_done(fd1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream 8-bit serial-in shift registers, never reset.
    always_ff @(posedge clk) begin
        out0 <= {out0[6:0], so0};
        out1 <= {out1[6:0], so1};
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, drive inputs, advance the model at the rising edge.
    task automatic cyc(input logic v, input logic [7:0] d);
        int   n;
        logic eb, el, er;
        @(negedge clk);
        n  = bq.size();
        eb = (n > 0) ? bq[0] : 1'b0;
        el = (n > 0) && ((n % 8) == 1);
        er = (n <= 8);
        chk("shift_out_lvl0", 8'(so0), 8'((n > 0) ? eb : 1'b0));
        chk("shift_out_lvl1", 8'(so1), 8'((n > 0) ? eb : 1'b1));
        chk("bit_valid", 8'({bv0, bv1}), 8'({(n > 0), (n > 0)}));
        chk("last_bit", 8'({lb0, lb1}), 8'({el, el}));
        chk("in_ready", 8'({rdy0, rdy1}), 8'({er, er}));
        chk("busy", 8'({busy0, busy1}), 8'({(n > 0), (n > 0)}));
        chk("frame_done", 8'({fd0, fd1}), 8'({fd_exp, fd_exp}));
        if (fd_exp && frames.size() > 0) begin
            chk("downstream_out_lvl0", out0, frames[0]);
            chk("downstream_out_lvl1", out1, frames[0]);
            frames.delete(0);
        end
        in_valid = v;
        in_data  = d;
        acc_last = v && er;
        @(posedge clk);
        fd_exp = el;
        if (n > 0) bq.delete(0);
        if (acc_last) begin
            for (int i = 7; i >= 0; i--) bq.push_back(d[i]);
            frames.push_back(d);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bq.delete();
        frames.delete();
        fd_exp = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 8'($urandom));
    endtask

    // Hold in_valid until accepted; while blocked, in_data wanders to prove it is ignored.
    task automatic send(input logic [7:0] d, input logic scramble);
        logic done;
        done = 1'b0;
        for (int t = 0; t < 40 && !done; t++) begin
            if (scramble && bq.size() > 8) cyc(1'b1, 8'($urandom));
            else                           cyc(1'b1, d);
            done = acc_last && (in_data == d);
        end
        if (!done) chk("accept_timeout", 8'(done), 8'd1);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        fd_exp   = 1'b0;
        acc_last = 1'b0;
        do_reset();
        idle(2);

        // Single frame
        send(8'hA5, 1'b0);
        idle(12);

        // Back-to-back through the hold buffer
        send(8'h3C, 1'b0);
        send(8'hF0, 1'b0);
        idle(20);

        // Bypass on the last-bit edge
        send(8'h55, 1'b0);
        for (int t = 0; t < 20 && bq.size() != 1; t++) cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h81);
        idle(12);

        // Backpressure with a changing blocked in_data
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        send(8'h56, 1'b1);
        idle(28);

        // Reset after three bits of 0xFF with 0x77 held
        send(8'hFF, 1'b0);
        send(8'h77, 1'b0);
        idle(2);
        do_reset();
        idle(14);

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 120) == 0) do_reset();
            else cyc($urandom_range(0, 3) != 0, 8'($urandom));
        end
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_serializer.md
# byte_serializer

Parallel-to-serial feeder for the 8-bit serial-in shift register stage. Accepts bytes over a valid/ready handshake and emits them one bit per clock, MSB first, on `shift_out`, which drives the shift register's `shift_in`. A one-entry hold buffer allows back-to-back bytes with no idle gap. `frame_done` marks the cycle in which the downstream register's `out[7:0]` equals the accepted byte.

## Interface
- `WIDTH`, default 8: bits per frame; must match the downstream shift register length.
- `IDLE_LEVEL`, default 1'b0: `shift_out` value whenever no frame is being sent.

- `clk`  input  1  single clock for all logic.
- `rst`  input  1  synchronous, active-high reset.
- `in_data`  input  WIDTH  byte to serialize.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  block can accept a byte this cycle.
- `shift_out`  output  1  serial bit to the downstream `shift_in`.
- `bit_valid`  output  1  `shift_out` carries a frame bit this cycle.
- `last_bit`  output  1  this cycle carries bit 0 (the final bit) of the frame.
- `frame_done`  output  1  one-cycle pulse: the downstream register now holds the complete byte.
- `busy`  output  1  high in SHIFT state, or when the hold buffer is full.

## Operation
- One clock domain. Reset is synchronous and active-high.
- Reset values:
  - state = IDLE; hold buffer empty; bit counter = 0.
  - `shift_out` = `IDLE_LEVEL`; `bit_valid`, `last_bit`, `frame_done` and `busy` = 0.
  - `in_ready` = 1.
- A byte is accepted on any edge where `in_valid && in_ready`. `in_data` is ignored otherwise.
- `in_ready` = hold buffer empty; it is registered-state only, with no combinational path from `in_valid`.
- FSM states: IDLE and SHIFT.
  - IDLE → SHIFT on accept. The byte loads directly into the active shift register and the counter loads WIDTH-1. Invariant: the hold buffer is always empty in IDLE.
  - In SHIFT, `shift_out` = active[WIDTH-1] and `bit_valid` = 1. Each cycle the active register shifts left and the counter decrements. `last_bit` = (counter == 0).
  - In SHIFT, an accept writes into the hold buffer.
- On the last-bit edge, priority is:
  1. If the hold buffer is full, load active from hold, empty hold, stay in SHIFT.
  2. Else, if an accept occurs on this same edge, bypass `in_data` straight into active and stay in SHIFT.
  3. Else, go to IDLE.
- `frame_done` is registered: it is high in the cycle after any `last_bit` cycle, independent of whether the next frame has started.
- Bit order is MSB first. After WIDTH shifts the downstream `out[WIDTH-1:0]` equals the byte bit-for-bit, because the first bit sent ends at `out[WIDTH-1]`.
- Reset mid-frame:
  - The frame and hold contents are discarded; no partial `frame_done` is produced.
  - Reset dominates a pending `frame_done`: it is 0 in the cycle after reset even if the previous cycle was `last_bit`.
- While IDLE, `shift_out` holds `IDLE_LEVEL`. The downstream register keeps shifting, so its contents are meaningful only on `frame_done`.

## Timing
- Byte accepted at edge k from IDLE:
  - Its MSB is on `shift_out` in cycle k+1.
  - Its LSB (`last_bit`) is in cycle k+WIDTH.
  - `frame_done` is in cycle k+WIDTH+1.
- Throughput is one byte per WIDTH cycles with zero gap when the hold buffer is full, or when a bypass accept lands on the last-bit edge.
- The hold buffer refills at the earliest one cycle after it drains, because `in_ready` rises in the cycle after the last-bit edge.
- Input-to-serial latency is 1 cycle. Input-to-`frame_done` latency is WIDTH+1 cycles when not blocked.

## Structure
- Shared package `serializer_pkg`:
  - state enum `ser_state_t` {IDLE, SHIFT};
  - localparam for the default WIDTH of 8;
  - counter width function `$clog2(WIDTH)`.
- One sub-module, `serializer_hold_buffer`: a one-entry WIDTH-bit register with full flag, write-on-accept and clear-on-drain.
- The FSM, active shift register and counter stay in the top-level block.

## Test plan
- Reset, then send 0xA5, accepted at edge k:
  - `shift_out` = 1,0,1,0,0,1,0,1 over cycles k+1..k+8;
  - `last_bit` at k+8, `frame_done` at k+9;
  - downstream `out` = 0xA5 at k+9.
- Stream 0x3C then 0xF0 with `in_valid` held:
  - 16 contiguous `bit_valid` cycles;
  - `frame_done` at k+9 (`out` = 0x3C) and k+17 (`out` = 0xF0);
  - `in_ready` low while hold is full.
- Bypass: hold empty, present 0x81 exactly on the 0x55 `last_bit` cycle:
  - 0x81's MSB follows with no gap;
  - `frame_done` for 0x55, then for 0x81 eight cycles later.
- Backpressure:
  - Send 0x12, then 0x34, with hold full; hold `in_valid` while also offering 0x56 → `in_ready` = 0 until hold drains.
  - 0x56 is then accepted unchanged, and output order is 0x12, 0x34, 0x56.
  - Changing `in_data` while `in_ready` = 0 has no effect.
- Reset after 3 bits of 0xFF, with 0x77 in hold:
  - next cycle `shift_out` = `IDLE_LEVEL`, `bit_valid` = 0, `in_ready` = 1, `busy` = 0;
  - no `frame_done` is produced and 0x77 is never sent.
- `IDLE_LEVEL` = 1: while idle, `shift_out` = 1 and `bit_valid` = 0; frame bits are unaffected.
